// File: rtl/masked_sbox_stage1.sv
// masked_sbox_stage1
//   First nonlinear stage of the masked (DOM) AES S-box, feeding the masked
//   GF(2^4) inverter.  For each Boolean share i of a tower-field element it
//   computes D_i, where the XOR of all D_i is sq_sc(Ah^Al) ^ Ah*Al, using a
//   DOM-indep GF(2^4) multiplier.  It also delays the Ah/Al shares so they
//   line up with the inverter output.
//
// Parameters
//   SHARES       number of Boolean shares (>= 2)
//   INV_LATENCY  downstream inverter latency in cycles (>= 1)
//
// Ports
//   ClkxCI       clock, rising edge
//   RstxBI       asynchronous active-low reset
//   _XxDI        shared input, share i = [8i+7:8i] (Ah high nibble, Al low)
//   ValidxSI     input qualifier
//   _ZxDI        fresh randomness, 4 bits per unordered share pair
//   _DxDO        shared inverter input, share i = [4i+3:4i] (latency 2)
//   ValidxSO     qualifies _DxDO
//   _AhxDO       Ah shares delayed by 2+INV_LATENCY cycles
//   _AlxDO       Al shares delayed by 2+INV_LATENCY cycles
//   NibValidxSO  qualifies _AhxDO/_AlxDO
//
// Build option
//   SBOX_STAGE1_HOLD_EN  when defined, each data register loads only when the
//                        valid bit entering its stage is set; otherwise all
//                        data registers load every cycle.

module masked_sbox_stage1 #(
   parameter int SHARES      = 2,
   parameter int INV_LATENCY = 2
) (
   input  logic                            ClkxCI,
   input  logic                            RstxBI,
   input  logic [8*SHARES-1:0]             _XxDI,
   input  logic                            ValidxSI,
   input  logic [2*SHARES*(SHARES-1)-1:0]  _ZxDI,
   output logic [4*SHARES-1:0]             _DxDO,
   output logic                            ValidxSO,
   output logic [4*SHARES-1:0]             _AhxDO,
   output logic [4*SHARES-1:0]             _AlxDO,
   output logic                            NibValidxSO
);

   localparam int NDEL = 2 + INV_LATENCY;

   typedef logic [3:0] nib_t;

   // GF(4) multiply, normal basis
   function automatic logic [1:0] mul2(input logic [1:0] a, input logic [1:0] b);
      logic t;
      t = (a[1] ^ a[0]) & (b[1] ^ b[0]);
      return {(a[1] & b[1]) ^ t, (a[0] & b[0]) ^ t};
   endfunction

   function automatic logic [1:0] scN(input logic [1:0] x);
      return {x[0], x[1] ^ x[0]};
   endfunction

   // GF(16) multiply over GF(4) halves
   function automatic nib_t mul4(input nib_t x, input nib_t y);
      logic [1:0] e;
      e = scN(mul2(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]));
      return {mul2(x[3:2], y[3:2]) ^ e, mul2(x[1:0], y[1:0]) ^ e};
   endfunction

   // {sq(xh^xl), scN2(sq(xl))}; linear, so it is applied per share
   function automatic nib_t sqSc(input nib_t x);
      logic [1:0] h;
      logic [1:0] l;
      h = x[3:2] ^ x[1:0];
      l = {x[0], x[1]};
      return {h[0], h[1], l[1] ^ l[0], l[1]};
   endfunction

   // lexicographic ordinal of the unordered pair (a,b), a < b
   function automatic int unsigned pairIdx(input int unsigned a, input int unsigned b);
      return a * SHARES - (a * (a + 1)) / 2 + (b - a - 1);
   endfunction

   logic [4*SHARES-1:0] ahIn;
   logic [4*SHARES-1:0] alIn;
   nib_t                sD    [SHARES];
   nib_t                termD [SHARES][SHARES];

   logic [NDEL-1:0]     validQ;
   nib_t                sQ    [SHARES];
   nib_t                termQ [SHARES][SHARES];
   logic [4*SHARES-1:0] dNext;
   logic [4*SHARES-1:0] dQ;
   logic [4*SHARES-1:0] ahQ [NDEL];
   logic [4*SHARES-1:0] alQ [NDEL];
   logic [NDEL-1:0]     loadEn;

`ifdef SBOX_STAGE1_HOLD_EN
   // stage k loads with the valid bit that is entering stage k
   assign loadEn = {validQ[NDEL-2:0], ValidxSI};
`else
   assign loadEn = '1;
`endif

   // stage-1 combinational terms; term[i][j] belongs to share domain i
   always_comb begin
      ahIn = '0;
      alIn = '0;
      for (int unsigned i = 0; i < SHARES; i++) begin
         ahIn[4*i +: 4] = _XxDI[8*i+4 +: 4];
         alIn[4*i +: 4] = _XxDI[8*i +: 4];
      end
      for (int unsigned i = 0; i < SHARES; i++) begin
         sD[i] = sqSc(ahIn[4*i +: 4] ^ alIn[4*i +: 4]);
         for (int unsigned j = 0; j < SHARES; j++) begin
            if (i == j)
               termD[i][j] = mul4(ahIn[4*i +: 4], alIn[4*i +: 4]);
            else
               termD[i][j] = mul4(ahIn[4*i +: 4], alIn[4*j +: 4])
                           ^ _ZxDI[4*pairIdx((i < j) ? i : j, (i < j) ? j : i) +: 4];
         end
      end
   end

   // compression of registered terms, one share domain at a time
   always_comb begin
      dNext = '0;
      for (int unsigned i = 0; i < SHARES; i++) begin
         dNext[4*i +: 4] = sQ[i];
         for (int unsigned j = 0; j < SHARES; j++)
            dNext[4*i +: 4] = dNext[4*i +: 4] ^ termQ[i][j];
      end
   end

   always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) begin
         validQ <= '0;
         dQ     <= '0;
         for (int unsigned i = 0; i < SHARES; i++) begin
            sQ[i] <= '0;
            for (int unsigned j = 0; j < SHARES; j++)
               termQ[i][j] <= '0;
         end
         for (int unsigned k = 0; k < NDEL; k++) begin
            ahQ[k] <= '0;
            alQ[k] <= '0;
         end
      end else begin
         validQ <= {validQ[NDEL-2:0], ValidxSI};
         if (loadEn[0]) begin
            sQ    <= sD;
            termQ <= termD;
            ahQ[0] <= ahIn;
            alQ[0] <= alIn;
         end
         if (loadEn[1])
            dQ <= dNext;
         for (int unsigned k = 1; k < NDEL; k++) begin
            if (loadEn[k]) begin
               ahQ[k] <= ahQ[k-1];
               alQ[k] <= alQ[k-1];
            end
         end
      end
   end

   assign _DxDO       = dQ;
   assign ValidxSO    = validQ[1];
   assign _AhxDO      = ahQ[NDEL-1];
   assign _AlxDO      = alQ[NDEL-1];
   assign NibValidxSO = validQ[NDEL-1];

endmodule

// File: tb/tb_masked_sbox_stage1.sv
// tb_masked_sbox_stage1
//   Bench for masked_sbox_stage1: one instance at SHARES=2/INV_LATENCY=2 and
//   one at SHARES=3/INV_LATENCY=1, driven with identical unmasked values under
//   independent random masks and Z.  Build option SBOX_STAGE1_HOLD_EN adds the
//   data-hold scenario.

module tb_masked_sbox_stage1;

   logic        clk = 1'b0;
   logic        rstn;
   logic [15:0] x2;
   logic [3:0]  z2;
   logic        v2;
   logic [7:0]  d2, ah2, al2;
   logic        vo2, nv2;
   logic [23:0] x3;
   logic [11:0] z3;
   logic        v3;
   logic [11:0] d3, ah3, al3;
   logic        vo3, nv3;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   masked_sbox_stage1 #(.SHARES(2), .INV_LATENCY(2)) dut2 (
      .ClkxCI(clk), .RstxBI(rstn), ._XxDI(x2), .ValidxSI(v2), ._ZxDI(z2),
      ._DxDO(d2), .ValidxSO(vo2), ._AhxDO(ah2), ._AlxDO(al2), .NibValidxSO(nv2));

   masked_sbox_stage1 #(.SHARES(3), .INV_LATENCY(1)) dut3 (
      .ClkxCI(clk), .RstxBI(rstn), ._XxDI(x3), .ValidxSI(v3), ._ZxDI(z3),
      ._DxDO(d3), .ValidxSO(vo3), ._AhxDO(ah3), ._AlxDO(al3), .NibValidxSO(nv3));

   // unmasked reference: sq_sc(Ah^Al) ^ mul4(Ah,Al), written bit-wise
   function automatic logic [1:0] gm2(input logic [1:0] a, input logic [1:0] b);
      logic t;
      t = (a[1] ^ a[0]) & (b[1] ^ b[0]);
      return {(a[1] & b[1]) ^ t, (a[0] & b[0]) ^ t};
   endfunction

   function automatic logic [3:0] gold(input logic [7:0] x);
      logic [3:0] a, b, s, m;
      logic [1:0] p, e;
      a = x[7:4];
      b = x[3:0];
      p = gm2(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]);
      e = {p[0], p[1] ^ p[0]};
      m = {gm2(a[3:2], b[3:2]) ^ e, gm2(a[1:0], b[1:0]) ^ e};
      s = a ^ b;
      return m ^ {s[2] ^ s[0], s[3] ^ s[1], s[0] ^ s[1], s[0]};
   endfunction

   function automatic logic [3:0] r2(input logic [7:0] d);
      return d[7:4] ^ d[3:0];
   endfunction

   function automatic logic [3:0] r3(input logic [11:0] d);
      return d[11:8] ^ d[7:4] ^ d[3:0];
   endfunction

   task automatic drive(input logic [7:0] x, input logic v);
      logic [7:0] m1, m2;
      m1 = 8'($urandom);
      m2 = 8'($urandom);
      x2 = {m1, x ^ m1};
      x3 = {m2, m1, x ^ m1 ^ m2};
      z2 = 4'($urandom);
      z3 = 12'($urandom);
      v2 = v;
      v3 = v;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(8'($urandom), 1'b1);
         step();
         tests++;
         if ({d2, vo2, ah2, al2, nv2, d3, vo3, ah3, al3, nv3} !== '0) begin
            fails++;
            $display("FAIL reset_outputs[%0d]: got d2=%h vo2=%b nv2=%b d3=%h vo3=%b nv3=%b want all zero",
                     i, d2, vo2, nv2, d3, vo3, nv3);
         end
      end
      drive(8'h00, 1'b0);
      rstn = 1'b1;
      step();
   endtask

   task automatic test_known();
      logic [7:0] kx [4];
      logic [3:0] kd [4];
      kx = '{8'hFF, 8'hF0, 8'h00, 8'h0F};
      kd = '{4'hF, 4'h1, 4'h0, 4'h1};
      for (int i = 0; i < 4; i++) begin
         drive(kx[i], 1'b1);
         step();
         drive(8'($urandom), 1'b0);
         step();
         tests++;
         if ({vo2, r2(d2)} !== {1'b1, kd[i]}) begin
            fails++;
            $display("FAIL known_d[%0h]: got valid=%b D=%h want valid=1 D=%h", kx[i], vo2, r2(d2), kd[i]);
         end
         step();
         step();
         tests++;
         if ({nv2, r2(ah2), r2(al2)} !== {1'b1, kx[i]}) begin
            fails++;
            $display("FAIL known_nib[%0h]: got valid=%b AhAl=%h%h want valid=1 AhAl=%h",
                     kx[i], nv2, r2(ah2), r2(al2), kx[i]);
         end
      end
   endtask

   task automatic test_exhaustive();
      logic [7:0] xn;
      for (int c = 0; c < 260; c++) begin
         if (c < 256) drive(8'(c), 1'b1);
         else         drive(8'($urandom), 1'b0);
         step();
         if (c >= 1 && c <= 256) begin
            xn = 8'(c - 1);
            tests++;
            if ({vo2, r2(d2)} !== {1'b1, gold(xn)}) begin
               fails++;
               $display("FAIL exh_d_s2[%0h]: got valid=%b D=%h want valid=1 D=%h", xn, vo2, r2(d2), gold(xn));
            end
            tests++;
            if ({vo3, r3(d3)} !== {1'b1, gold(xn)}) begin
               fails++;
               $display("FAIL exh_d_s3[%0h]: got valid=%b D=%h want valid=1 D=%h", xn, vo3, r3(d3), gold(xn));
            end
         end
         if (c >= 3 && c <= 258) begin
            xn = 8'(c - 3);
            tests++;
            if ({nv2, r2(ah2), r2(al2)} !== {1'b1, xn}) begin
               fails++;
               $display("FAIL exh_nib_s2[%0h]: got valid=%b AhAl=%h%h want valid=1 AhAl=%h",
                        xn, nv2, r2(ah2), r2(al2), xn);
            end
         end
         if (c >= 2 && c <= 257) begin
            xn = 8'(c - 2);
            tests++;
            if ({nv3, r3(ah3), r3(al3)} !== {1'b1, xn}) begin
               fails++;
               $display("FAIL exh_nib_s3[%0h]: got valid=%b AhAl=%h%h want valid=1 AhAl=%h",
                        xn, nv3, r3(ah3), r3(al3), xn);
            end
         end
      end
   endtask

   task automatic test_bubbles();
      logic       pat [6];
      logic [7:0] xs  [6];
      logic       ev, en2, en3;
      pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      xs  = '{8'h3C, 8'h00, 8'hA7, 8'h5E, 8'h00, 8'hC1};
      for (int c = 0; c < 10; c++) begin
         if (c < 6) drive(xs[c], pat[c]);
         else       drive(8'($urandom), 1'b0);
         step();
         ev  = (c >= 1 && c <= 6) ? pat[c-1] : 1'b0;
         en2 = (c >= 3 && c <= 8) ? pat[c-3] : 1'b0;
         en3 = (c >= 2 && c <= 7) ? pat[c-2] : 1'b0;
         tests++;
         if ({vo2, nv2, vo3, nv3} !== {ev, en2, ev, en3}) begin
            fails++;
            $display("FAIL bubble_valid[%0d]: got vo2=%b nv2=%b vo3=%b nv3=%b want %b %b %b %b",
                     c, vo2, nv2, vo3, nv3, ev, en2, ev, en3);
         end
         if (ev) begin
            tests++;
            if ({r2(d2), r3(d3)} !== {gold(xs[c-1]), gold(xs[c-1])}) begin
               fails++;
               $display("FAIL bubble_d[%0d]: got D2=%h D3=%h want %h", c, r2(d2), r3(d3), gold(xs[c-1]));
            end
         end
         if (en2) begin
            tests++;
            if ({r2(ah2), r2(al2)} !== xs[c-3]) begin
               fails++;
               $display("FAIL bubble_nib[%0d]: got AhAl=%h%h want %h", c, r2(ah2), r2(al2), xs[c-3]);
            end
         end
      end
   endtask

   task automatic test_mask_indep();
      logic [3:0] first;
      logic       varied;
      first  = '0;
      varied = 1'b0;
      for (int c = 0; c < 1001; c++) begin
         if (c < 1000) drive(8'h53, 1'b1);
         else          drive(8'($urandom), 1'b0);
         step();
         if (c >= 1) begin
            tests++;
            if ({r2(d2), r3(d3)} !== {4'hF, 4'hF}) begin
               fails++;
               $display("FAIL mask_const[%0d]: got D2=%h D3=%h want F", c, r2(d2), r3(d3));
            end
            if (c == 1) first = d2[3:0];
            else if (d2[3:0] !== first) varied = 1'b1;
         end
      end
      tests++;
      if (varied !== 1'b1) begin
         fails++;
         $display("FAIL mask_share_varies: got share0 stuck at %h want varying", first);
      end
      for (int c = 0; c < 4; c++) begin
         drive(8'($urandom), 1'b0);
         step();
      end
   endtask

   task automatic test_reset_midstream();
      for (int c = 0; c < 3; c++) begin
         drive(8'($urandom), 1'b1);
         step();
      end
      rstn = 1'b0;
      #1;
      tests++;
      if ({d2, vo2, ah2, al2, nv2, d3, vo3, ah3, al3, nv3} !== '0) begin
         fails++;
         $display("FAIL midreset_clear: got d2=%h vo2=%b nv2=%b d3=%h vo3=%b nv3=%b want all zero",
                  d2, vo2, nv2, d3, vo3, nv3);
      end
      step();
      step();
      drive(8'($urandom), 1'b0);
      rstn = 1'b1;
      for (int c = 0; c < 6; c++) begin
         drive(8'($urandom), 1'b0);
         step();
         tests++;
         if ({vo2, nv2, vo3, nv3} !== 4'b0000) begin
            fails++;
            $display("FAIL midreset_novalid[%0d]: got vo2=%b nv2=%b vo3=%b nv3=%b want 0000",
                     c, vo2, nv2, vo3, nv3);
         end
      end
   endtask

`ifdef SBOX_STAGE1_HOLD_EN
   task automatic test_hold();
      logic [7:0] held;
      drive(8'h53, 1'b1);
      step();
      drive(8'($urandom), 1'b0);
      step();
      held = d2;
      tests++;
      if ({vo2, r2(held)} !== {1'b1, 4'hF}) begin
         fails++;
         $display("FAIL hold_first: got valid=%b D=%h want valid=1 D=F", vo2, r2(held));
      end
      for (int c = 0; c < 5; c++) begin
         drive(8'($urandom), 1'b0);
         step();
         tests++;
         if (d2 !== held) begin
            fails++;
            $display("FAIL hold_stable[%0d]: got D shares=%h want %h", c, d2, held);
         end
      end
   endtask
`endif

   initial begin
      rstn = 1'b0;
      drive(8'h00, 1'b0);
      test_reset();
      test_known();
      test_exhaustive();
      test_bubbles();
      test_mask_indep();
      test_reset_midstream();
`ifdef SBOX_STAGE1_HOLD_EN
      test_hold();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
